// File: rtl/keccak_theta_rowserial.sv
// Row-serial Keccak theta: buffers a 25-lane state row by row, then emits theta-applied rows.
// Optional macro KECCAK_THETA_PINGPONG_EN adds a second bank so loading overlaps emission.
module keccak_theta_rowserial #(
   parameter int W   = 8,
   parameter int ROT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [5*W-1:0] in_row,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [5*W-1:0] out_row,
   output logic [2:0]     out_y,
   output logic           out_last,
   output logic           busy
);
   typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

   function automatic logic [W-1:0] rotl(input logic [W-1:0] v);
      logic [2*W-1:0] dbl;
      dbl = {v, v} << ROT;
      return dbl[2*W-1 -: W];
   endfunction

   function automatic logic [5*W-1:0] theta_d(input logic [5*W-1:0] c);
      logic [5*W-1:0] d;
      d = '0;
      for (int x = 0; x < 5; x++) begin
         d[x*W +: W] = c[((x + 4) % 5)*W +: W] ^ rotl(c[((x + 1) % 5)*W +: W]);
      end
      return d;
   endfunction

   // The single-bank build pins both bank pointers to bank 0.
   function automatic logic nxt_bank(input logic b);
`ifdef KECCAK_THETA_PINGPONG_EN
      return ~b;
`else
      return b & 1'b0;
`endif
   endfunction

   state_t         state_r, state_nxt;
   logic [5*W-1:0] rows_r [0:1][0:4];
   logic [5*W-1:0] c_r [0:1];
   logic [5*W-1:0] d_r [0:1];
   logic [1:0]     full_r, full_nxt;
   logic           lb_r, lb_nxt, eb_r, eb_nxt;
   logic [2:0]     ycnt_r, ycnt_nxt, ecnt_r, ecnt_nxt;
   logic           in_ready_r, in_ready_nxt;
   logic           out_valid_r, out_valid_nxt;
   logic           out_last_r, out_last_nxt;
   logic           busy_r, busy_nxt;
   logic [5*W-1:0] out_row_r, row_nxt;
   logic           ld_fire_s, ld_done_s, out_fire_s, nb_s;
   logic [5*W-1:0] c_new_s, d_new_s;

   // Handshake decode and the D vector of a state completing on this edge.
   always_comb begin
      ld_fire_s  = in_valid && in_ready_r;
      ld_done_s  = ld_fire_s && (ycnt_r == 3'd4);
      out_fire_s = out_valid_r && out_ready;
      nb_s       = nxt_bank(eb_r);
      if (ycnt_r == 3'd0) begin
         c_new_s = in_row;
      end else begin
         c_new_s = c_r[lb_r] ^ in_row;
      end
      d_new_s = theta_d(c_new_s);
   end

   // Next-state and next-output logic for the load and emit sides.
   always_comb begin
      state_nxt = state_r;
      ycnt_nxt  = ycnt_r;
      ecnt_nxt  = ecnt_r;
      lb_nxt    = lb_r;
      eb_nxt    = eb_r;
      full_nxt  = full_r;
      row_nxt   = out_row_r;
      if (ld_done_s) begin
         ycnt_nxt       = 3'd0;
         full_nxt[lb_r] = 1'b1;
         lb_nxt         = nxt_bank(lb_r);
      end else if (ld_fire_s) begin
         ycnt_nxt = ycnt_r + 3'd1;
      end else begin
         ycnt_nxt = ycnt_r;
      end
      case (state_r)
         LOAD: begin
            if (ld_done_s) begin
               state_nxt = EMIT;
               eb_nxt    = lb_r;
               ecnt_nxt  = 3'd0;
               row_nxt   = rows_r[lb_r][0] ^ d_new_s;
            end else begin
               state_nxt = LOAD;
            end
         end
         EMIT: begin
            if (out_fire_s && (ecnt_r == 3'd4)) begin
               full_nxt[eb_r] = 1'b0;
               ecnt_nxt       = 3'd0;
               eb_nxt         = nb_s;
               // Hand over to the other bank without a bubble when it is ready.
               if (full_r[nb_s] && (nb_s != eb_r)) begin
                  row_nxt = rows_r[nb_s][0] ^ d_r[nb_s];
               end else if (ld_done_s && (lb_r == nb_s)) begin
                  row_nxt = rows_r[nb_s][0] ^ d_new_s;
               end else begin
                  state_nxt = LOAD;
               end
            end else if (out_fire_s) begin
               ecnt_nxt = ecnt_r + 3'd1;
               row_nxt  = rows_r[eb_r][ecnt_r + 3'd1] ^ d_r[eb_r];
            end else begin
               ecnt_nxt = ecnt_r;
            end
         end
         default: begin
            state_nxt = LOAD;
         end
      endcase
      in_ready_nxt  = ~full_nxt[lb_nxt];
      out_valid_nxt = (state_nxt == EMIT);
      out_last_nxt  = (state_nxt == EMIT) && (ecnt_nxt == 3'd4);
      busy_nxt      = (ycnt_nxt != 3'd0) || (|full_nxt);
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= LOAD;
         ycnt_r      <= 3'd0;
         ecnt_r      <= 3'd0;
         lb_r        <= 1'b0;
         eb_r        <= 1'b0;
         full_r      <= 2'b00;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
         out_row_r   <= '0;
      end else begin
         state_r     <= state_nxt;
         ycnt_r      <= ycnt_nxt;
         ecnt_r      <= ecnt_nxt;
         lb_r        <= lb_nxt;
         eb_r        <= eb_nxt;
         full_r      <= full_nxt;
         in_ready_r  <= in_ready_nxt;
         out_valid_r <= out_valid_nxt;
         out_last_r  <= out_last_nxt;
         busy_r      <= busy_nxt;
         out_row_r   <= row_nxt;
      end
   end

   // Row buffers, column parities and per-bank D vectors.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int y = 0; y < 5; y++) begin
               rows_r[b][y] <= '0;
            end
            c_r[b] <= '0;
            d_r[b] <= '0;
         end
      end else begin
         if (ld_fire_s) begin
            rows_r[lb_r][ycnt_r] <= in_row;
            c_r[lb_r]            <= c_new_s;
         end
         if (ld_done_s) begin
            d_r[lb_r] <= d_new_s;
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_row   = out_row_r;
   assign out_y     = ecnt_r;
   assign out_last  = out_last_r;
   assign busy      = busy_r;
endmodule

// File: doc/keccak_theta_rowserial.md
Name: keccak_theta_rowserial

Overview:
- Row-serial, parametrised-lane-width Keccak theta step for port-serial round datapaths.
- Accepts one plane row (5 lanes, fixed y) per transfer and buffers the full 25-lane state.
- Accumulates the column parities C[x] while loading, then emits theta-applied rows over a valid/ready stream.
- Lane width W and the theta rotation amount are parameters, so Keccak-f[25..1600] and test variants share one block.

Parameters:
- W, 8, lane width in bits; legal 1..64 (state = 25*W).
- ROT, 1, left-rotation applied to C[x+1] in D; legal 0..W-1 (standard Keccak = 1).

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_row holds a valid row.
- in_ready  out  1  block accepts a row this cycle.
- in_row  in  5*W  lanes of row y; in_row[x*W +: W] = lane (x,y); y is implicit, 0..4 in arrival order.
- out_valid  out  1  out_row valid.
- out_ready  in  1  downstream accepts out_row.
- out_row  out  5*W  theta result for row out_y, same lane packing as in_row.
- out_y  out  3  index of the emitted row, 0..4.
- out_last  out  1  high with out_valid when out_y==4.
- busy  out  1  any buffered, unemitted state present.

Behaviour:
- Clock and reset are fixed: single clock clk; rst is synchronous, active-high.
- Reset values: in_ready=1, out_valid=0, out_y=0, out_last=0, busy=0, row buffers=0, C registers=0, row counters=0, out_row=0.
- Reset mid-load or mid-emit discards all buffered rows and parities. The next accepted row is row 0 of a new state.
- A transfer occurs when valid && ready on the same edge. No transfer without both.
- FSM states are LOAD and EMIT.
- LOAD:
  - in_ready=1 and out_valid=0.
  - On each accepted row, store it in buf[ycnt].
  - C <= (ycnt==0) ? in_row : C ^ in_row (per lane).
  - ycnt increments. On the 5th accept (ycnt==4), go to EMIT with ycnt=0.
- EMIT:
  - in_ready=0 and out_valid=1.
  - out_row lane x = buf[ecnt][x] ^ C[(x+4)%5] ^ rotl(C[(x+1)%5], ROT), all within W bits.
  - out_y = ecnt.
  - On each output transfer, ecnt increments. After the transfer with ecnt==4, go to LOAD with ecnt=0.
- out_row, out_y and out_last are driven only from registers; there is no combinational path from in_* to out_*.
- out_row, out_y and out_last hold stable while out_valid && !out_ready.
- Latency: the first output row is valid the cycle after the 5th input accept.
- Throughput without the optional feature: one state per 10 cycles minimum.
- in_valid during EMIT is ignored (in_ready=0). The input is not consumed.
- busy=1 from the first accepted row until the last output transfer.

Optional Feature:
- Macro: KECCAK_THETA_PINGPONG_EN.
- Defined:
  - Two banks, each with its own row buffer and C registers.
  - The load bank and the emit bank alternate.
  - in_ready=1 whenever the load bank is not full; a full bank that is still waiting to emit deasserts in_ready.
  - Loading of state N+1 overlaps emission of state N, and states emit in acceptance order.
  - If the load bank fills on the same edge the emit bank drains, the banks swap and out_valid stays high with no bubble.
  - Steady-state throughput: one state per 5 cycles when out_ready=1 and in_valid=1.
  - Reset clears both banks and returns the bank pointer to bank 0.
- Undefined: single-bank LOAD/EMIT behaviour exactly as specified above.

Test Plan:
- W=8, ROT=1. Feed one state with lane(0,0)=0x01 and all other lanes 0, out_ready=1.
  - Rows y=0..4 emit with lanes x1=0x01 and x4=0x02; lanes x2 and x3 are 0x00.
  - Lane x0 is 0x01 at y=0 and 0x00 otherwise.
  - out_last=1 only at y=4; the first out_valid appears 1 cycle after the 5th accept.
- All lanes 0xFF -> every output lane 0xFF. A second state with all lanes 0x00 -> all 0x00, with no carry-over of C.
- Backpressure: hold out_ready=0 for 3 cycles at out_y=2.
  - out_row and out_y stay constant and in_ready stays 0 (single-bank build).
  - After release, rows 2..4 emit in order.
- Reset mid-load: accept 3 rows, assert rst for 1 cycle, then load the single-bit state.
  - Output matches the first scenario exactly, and busy=0 immediately after reset.
- Parameter sweep at W=1, W=16 and W=64 with ROT=1, plus W=8 with ROT=3, using random states.
  - Results match a software theta reference.
- KECCAK_THETA_PINGPONG_EN, 4 back-to-back random states with in_valid=1 and out_ready=1:
  - 20 output rows, in order, on consecutive cycles after the first 5 load cycles (25 cycles total).
  - Without the macro, the same stimulus takes 40 cycles.
